// File: rtl/teclado_cajero_pkg.sv
// Shared definitions for the ATM keypad front-end.
//   - estado_t: scan/debounce FSM states (3-bit encoding)
//   - key codes for the non-digit keys
//   - helpers: matrix decode, lowest low row, single-row pattern
package teclado_cajero_pkg;

  typedef enum logic [2:0] {
    ESCANEO       = 3'd0,
    REBOTE        = 3'd1,
    ACEPTAR       = 3'd2,
    ESPERA_SOLTAR = 3'd3
  } estado_t;

  localparam logic [3:0] TECLA_AST    = 4'hA;  // '*'
  localparam logic [3:0] TECLA_NUM    = 4'hB;  // '#'
  localparam logic [3:0] TECLA_LETRA  = 4'hF;  // A-D, always ignored
  localparam logic [3:0] FILAS_LIBRES = 4'hF;  // no row pulled low

  // Layout: r0 1 2 3 A | r1 4 5 6 B | r2 7 8 9 C | r3 * 0 # D
  function automatic logic [3:0] decodificar(input logic [1:0] fila, input logic [1:0] col);
    logic [3:0] code;
    unique case ({fila, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = TECLA_AST;
      4'b11_01: code = 4'd0;
      4'b11_10: code = TECLA_NUM;
      default:  code = TECLA_LETRA;
    endcase
    return code;
  endfunction

  function automatic logic es_digito(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // Lowest-index row that reads low; only meaningful when some row is low.
  function automatic logic [1:0] fila_baja_min(input logic [3:0] filas);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!filas[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Row pattern expected while exactly one key on row 'fila' is held.
  function automatic logic [3:0] patron_fila(input logic [1:0] fila);
    return ~(4'b0001 << fila);
  endfunction

endpackage

// File: rtl/teclado_cajero_acumulador_monto.sv
// acumulador_monto: decimal amount accumulator for the keypad front-end.
//   clk, rst       clock, asynchronous active-low reset
//   digit, valid   accepted digit (0-9) to append as acc*10+digit
//   clear          '*' : drop acc, count and overflow flag
//   confirm        '#' : publish acc on monto, pulse monto_stb next cycle, then clear
//   monto          last confirmed amount
//   monto_stb      one-cycle pulse, monto valid
//   desborde       sticky: a digit was dropped because MAX_DIGITS were already held
module acumulador_monto
  import teclado_cajero_pkg::*;
#(
  parameter int MAX_DIGITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit,
  input  logic        valid,
  input  logic        clear,
  input  logic        confirm,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        desborde
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic [31:0]      acc_x10_d;

  // x10 as shift-and-add; 9 digits never exceed 32 bits.
  assign acc_x10_d = (acc << 3) + (acc << 1) + {28'd0, digit};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      count     <= '0;
      monto     <= '0;
      monto_stb <= 1'b0;
      desborde  <= 1'b0;
    end else begin
      monto_stb <= 1'b0;
      if (confirm) begin
        monto     <= acc;
        monto_stb <= 1'b1;
        acc       <= '0;
        count     <= '0;
        desborde  <= 1'b0;
      end else if (clear) begin
        acc      <= '0;
        count    <= '0;
        desborde <= 1'b0;
      end else if (valid) begin
        if (count < CNT_W'(MAX_DIGITS)) begin
          acc   <= acc_x10_d;
          count <= count + CNT_W'(1);
        end else begin
          desborde <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/teclado_cajero.sv
// teclado_cajero: 4x4 keypad front-end for the ATM controller.
// Scans the active-low matrix, debounces press and release, decodes the key and
// either emits PIN digits or accumulates a decimal amount.
//   clk          system clock
//   rst          asynchronous, active-low reset
//   filas[3:0]   keypad rows, active-low, pulled up
//   modo_monto   0 = PIN mode, 1 = amount mode
//   columnas     keypad column drive, active-low
//   digito       last accepted PIN digit
//   digito_stb   one-cycle pulse, digito valid
//   monto        confirmed amount
//   monto_stb    one-cycle pulse, monto valid
//   desborde     sticky amount-overflow flag
// filas is expected to be already synchronous to clk (slow mechanical keys,
// and the debounce filter rejects any single-cycle disturbance).
module teclado_cajero
  import teclado_cajero_pkg::*;
#(
  parameter int SCAN_CYCLES      = 2,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int MONTO_MAX_DIGITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  filas,
  input  logic        modo_monto,
  output logic [3:0]  columnas,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        desborde
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  estado_t           estado, estado_n;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_n;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_n;
  logic [1:0]        col, col_n;
  logic [1:0]        fila_lat, fila_lat_n;
  logic [3:0]        digito_n;
  logic              pin_stb_n;
  logic [3:0]        tecla;
  logic              acc_valid, acc_clear, acc_confirm;

  // Column and latched row together identify the key; col is frozen while
  // the press is being debounced and accepted.
  assign tecla = decodificar(fila_lat, col);

  // All columns low while waiting for release so any held key keeps a row low.
  assign columnas = (estado == ESPERA_SOLTAR) ? 4'b0000 : ~(4'b0001 << col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado     <= ESPERA_SOLTAR;
      scan_cnt   <= '0;
      deb_cnt    <= '0;
      col        <= '0;
      fila_lat   <= '0;
      digito     <= '0;
      digito_stb <= 1'b0;
    end else begin
      estado     <= estado_n;
      scan_cnt   <= scan_cnt_n;
      deb_cnt    <= deb_cnt_n;
      col        <= col_n;
      fila_lat   <= fila_lat_n;
      digito     <= digito_n;
      digito_stb <= pin_stb_n;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would make synthesis infer a latch.
  always_comb begin
    estado_n    = estado;
    scan_cnt_n  = scan_cnt;
    deb_cnt_n   = deb_cnt;
    col_n       = col;
    fila_lat_n  = fila_lat;
    digito_n    = digito;
    pin_stb_n   = 1'b0;
    acc_valid   = 1'b0;
    acc_clear   = 1'b0;
    acc_confirm = 1'b0;

    unique case (estado)
      ESCANEO: begin
        if (filas != FILAS_LIBRES) begin
          fila_lat_n = fila_baja_min(filas);
          deb_cnt_n  = '0;
          estado_n   = REBOTE;
        end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
          scan_cnt_n = '0;
          col_n      = col + 2'd1;  // col 3 wraps to col 0
        end else begin
          scan_cnt_n = scan_cnt + SCAN_W'(1);
        end
      end

      REBOTE: begin
        // A second low row (ghosting or two keys) counts as a glitch.
        if (filas == patron_fila(fila_lat)) begin
          if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            estado_n = ACEPTAR;
            // digito is loaded on entry to ACEPTAR so it is already stable
            // one cycle before digito_stb rises.
            if (!modo_monto && es_digito(tecla)) digito_n = tecla;
          end else begin
            deb_cnt_n = deb_cnt + DEB_W'(1);
          end
        end else begin
          estado_n   = ESCANEO;
          scan_cnt_n = '0;
        end
      end

      ACEPTAR: begin
        estado_n  = ESPERA_SOLTAR;
        deb_cnt_n = '0;
        if (modo_monto) begin
          acc_valid   = es_digito(tecla);
          acc_clear   = (tecla == TECLA_AST);
          acc_confirm = (tecla == TECLA_NUM);
        end else begin
          pin_stb_n = es_digito(tecla);
        end
      end

      ESPERA_SOLTAR: begin
        if (filas == FILAS_LIBRES) begin
          if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            estado_n   = ESCANEO;
            col_n      = '0;
            scan_cnt_n = '0;
            deb_cnt_n  = '0;
          end else begin
            deb_cnt_n = deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_cnt_n = '0;
        end
      end

      default: estado_n = ESPERA_SOLTAR;
    endcase
  end

  acumulador_monto #(
    .MAX_DIGITS(MONTO_MAX_DIGITS)
  ) u_acumulador (
    .clk      (clk),
    .rst      (rst),
    .digit    (tecla),
    .valid    (acc_valid),
    .clear    (acc_clear),
    .confirm  (acc_confirm),
    .monto    (monto),
    .monto_stb(monto_stb),
    .desborde (desborde)
  );

endmodule

// File: tb/tb_teclado_cajero.sv
// Testbench for teclado_cajero: keypad matrix model, directed scenarios and
// randomized key sequences. Expected strobes are queued by a key-level
// reference model and checked by an independent output monitor.
module tb_teclado_cajero;

  localparam int DEB = 4;
  localparam int GAP = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  filas;
  logic        modo_monto = 1'b0;
  logic [3:0]  columnas;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        desborde;

  // held[r*4+c] = key at row r, column c is physically pressed
  logic [15:0] held = '0;

  always #5 clk = ~clk;

  // A row reads low when a held key in that row sits on a driven column.
  always_comb begin
    filas = 4'hF;
    for (int r = 0; r < 4; r++) filas[r] = ~|(held[r*4 +: 4] & ~columnas);
  end

  teclado_cajero dut (
    .clk       (clk),
    .rst       (rst),
    .filas     (filas),
    .modo_monto(modo_monto),
    .columnas  (columnas),
    .digito    (digito),
    .digito_stb(digito_stb),
    .monto     (monto),
    .monto_stb (monto_stb),
    .desborde  (desborde)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_monto;
    logic [31:0] val;
  } ev_t;

  ev_t     exp_q[$];
  string   mapa = "123A456B789C*0#D";
  longint  m_acc  = 0;
  int      m_cnt  = 0;
  bit      m_desb = 1'b0;

  function automatic int key_idx(input byte ch);
    for (int i = 0; i < 16; i++) if (mapa[i] == ch) return i;
    return 3;
  endfunction

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_desb = 1'b0;
  endtask

  // Effect of one accepted key, at the level of an ATM user.
  task automatic modelo(input byte ch);
    ev_t e;
    if (ch >= "0" && ch <= "9") begin
      if (!modo_monto) begin
        e.is_monto = 1'b0;
        e.val      = 32'(ch - "0");
        exp_q.push_back(e);
      end else if (m_cnt < 9) begin
        m_acc = m_acc * 10 + (ch - "0");
        m_cnt++;
      end else begin
        m_desb = 1'b1;
      end
    end else if (modo_monto && ch == "#") begin
      e.is_monto = 1'b1;
      e.val      = 32'(m_acc);
      exp_q.push_back(e);
      model_reset();
    end else if (modo_monto && ch == "*") begin
      model_reset();
    end
  endtask

  // Press a key for 'hold' cycles, release, wait for release debounce.
  // Holds of DEB cycles or fewer can never pass the debounce filter.
  task automatic pulsar(input byte ch, input int hold);
    int k;
    k = key_idx(ch);
    if (hold > DEB) modelo(ch);
    @(negedge clk);
    held[k] = 1'b1;
    repeat (hold) @(negedge clk);
    held[k] = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic set_modo(input logic m);
    @(negedge clk);
    modo_monto = m;
  endtask

  // ---------------- monitor ----------------
  logic [3:0] prev_digito = '0;

  always @(negedge clk) begin
    ev_t e;
    if (rst && (digito_stb || monto_stb)) begin
      check("strobes_exclusive", 32'(digito_stb & monto_stb), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: digito_stb=%0b digito=%0d monto_stb=%0b monto=%0d expected none (t=%0t)",
                 digito_stb, digito, monto_stb, monto, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind_monto", 32'(monto_stb), 32'(e.is_monto));
        if (e.is_monto) begin
          check("monto", monto, e.val);
        end else begin
          check("digito", 32'(digito), e.val);
          check("digito_stable_before", 32'(prev_digito), e.val);
        end
      end
    end
    prev_digito = digito;
  end

  // ---------------- stimulus ----------------
  initial begin
    bool_found_t : begin end
  end

  initial begin
    byte ch;
    int  waited;
    bit  found;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_columnas", 32'(columnas), 32'd0);
    check("rst_digito", 32'(digito), 32'd0);
    check("rst_digito_stb", 32'(digito_stb), 32'd0);
    check("rst_monto", monto, 32'd0);
    check("rst_monto_stb", 32'(monto_stb), 32'd0);
    check("rst_desborde", 32'(desborde), 32'd0);
    rst = 1'b1;
    repeat (GAP) @(negedge clk);

    // 1. PIN digit
    set_modo(1'b0);
    pulsar("7", 20);
    check("digito_hold_7", 32'(digito), 32'd7);

    // 2. glitch then real press
    pulsar("5", 2);
    check("glitch_no_change", 32'(digito), 32'd7);
    pulsar("5", 20);

    // 3. amount 1250, accumulator cleared afterwards
    set_modo(1'b1);
    pulsar("1", 20);
    pulsar("2", 20);
    pulsar("5", 20);
    pulsar("0", 20);
    pulsar("#", 20);
    check("desborde_1250", 32'(desborde), 32'd0);
    pulsar("#", 20);

    // 4. overflow
    for (int i = 0; i < 9; i++) pulsar("9", 20);
    check("desborde_9_digits", 32'(desborde), 32'd0);
    pulsar("9", 20);
    check("desborde_10th", 32'(desborde), 32'd1);
    pulsar("#", 20);
    check("desborde_after_hash", 32'(desborde), 32'd0);

    // 5. '*' clears; A and # ignored in PIN mode
    pulsar("4", 20);
    pulsar("2", 20);
    pulsar("*", 20);
    pulsar("8", 20);
    pulsar("#", 20);
    set_modo(1'b0);
    pulsar("A", 20);
    pulsar("#", 20);
    pulsar("*", 20);

    // 6. reset while '3' is being debounced, key still held at release
    @(negedge clk);
    held[key_idx("3")] = 1'b1;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 40) begin
      @(negedge clk);
      waited++;
      found = (columnas == 4'b1011) && (filas != 4'hF);
    end
    check("reach_col2_with_3_held", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst6_columnas", 32'(columnas), 32'd0);
    check("rst6_digito", 32'(digito), 32'd0);
    check("rst6_digito_stb", 32'(digito_stb), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    held[key_idx("3")] = 1'b0;
    repeat (GAP) @(negedge clk);
    check("held_at_reset_ignored", 32'(digito), 32'd0);
    pulsar("3", 20);

    // 7. two rows on column 0 is a glitch; single row-1 press is '4'
    @(negedge clk);
    held[key_idx("4")] = 1'b1;
    held[key_idx("7")] = 1'b1;
    repeat (20) @(negedge clk);
    held = '0;
    repeat (GAP) @(negedge clk);
    check("multirow_no_event", 32'(digito), 32'd3);
    pulsar("4", 20);

    // Randomized key sequences in both modes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) set_modo(1'($urandom_range(0, 1)));
      ch = mapa[$urandom_range(0, 15)];
      if ($urandom_range(0, 3) == 0) pulsar(ch, $urandom_range(1, DEB));
      else                           pulsar(ch, $urandom_range(20, 29));
      if (modo_monto) check("rand_desborde", 32'(desborde), 32'(m_desb));
    end
    set_modo(1'b1);
    pulsar("#", 20);

    repeat (30) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
